// File: rtl/sccb_arbiter.sv
// sccb_arbiter: shares one sccb_protocol write engine between the
// power-up table sequencer (req0) and the runtime register writer (req1).
module sccb_arbiter #(
    parameter int PRIORITY_MODE = 0,
    parameter int GAP_CYCLES    = 250,
    parameter int BUSY_TIMEOUT  = 16,
    parameter int DONE_TIMEOUT  = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic [7:0] addr0,
    input  logic [7:0] data0,
    output logic       ack0,
    input  logic       req1,
    input  logic [7:0] addr1,
    input  logic [7:0] data1,
    output logic       ack1,
    output logic       err,
    input  logic       sccb_ready,
    output logic       sccb_start,
    output logic [7:0] sccb_sub_address,
    output logic [7:0] sccb_set_data,
    output logic       owner,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        FINISH,
        GAP
    } state_t;

    localparam logic [15:0] GAP_LOAD  = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] BUSY_LAST = 16'(BUSY_TIMEOUT - 2);
    localparam logic [15:0] DONE_LAST = 16'(DONE_TIMEOUT - 2);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic        err_q, err_d;
    logic        grant_sel;

    // last_q holds the requester served most recently; reset value 1
    // makes req0 the favoured side of the first round-robin tie.
    always_comb begin
        grant_sel = ~req0;
        if (PRIORITY_MODE == 0 && req0 && req1) begin
            grant_sel = ~last_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        owner_d = owner_q;
        last_d  = last_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if ((req0 || req1) && sccb_ready) begin
                    addr_d  = grant_sel ? addr1 : addr0;
                    data_d  = grant_sel ? data1 : data0;
                    owner_d = grant_sel;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                err_d   = 1'b0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!sccb_ready) begin
                    cnt_d   = '0;
                    state_d = WAIT_DONE;
                end else if (cnt_q == BUSY_LAST) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            WAIT_DONE: begin
                if (sccb_ready) begin
                    err_d   = 1'b0;
                    state_d = FINISH;
                end else if (cnt_q == DONE_LAST) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            FINISH: begin
                last_d  = owner_q;
                cnt_d   = GAP_LOAD;
                state_d = GAP;
            end
            GAP: begin
                if (cnt_q == 16'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign sccb_start       = (state_q == ISSUE);
    assign ack0             = (state_q == FINISH) && !owner_q;
    assign ack1             = (state_q == FINISH) && owner_q;
    assign err              = (state_q == FINISH) && err_q;
    assign busy             = (state_q != IDLE);
    assign owner            = owner_q;
    assign sccb_sub_address = addr_q;
    assign sccb_set_data    = data_q;

endmodule

// File: tb/tb_sccb_arbiter.sv
// tb_sccb_arbiter: directed and randomized checks of sccb_arbiter against
// a transaction-level model of arbitration, gap and timeout timing.
module tb_sccb_arbiter;

    localparam int GAP_A = 250;
    localparam int BT_A  = 16;
    localparam int DT_A  = 20000;
    localparam int GAP_B = 8;
    localparam int BT_B  = 4;
    localparam int DT_B  = 30;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    logic [1:0]      req0_v, req1_v, rdy_v;
    logic [1:0][7:0] addr0_v, data0_v, addr1_v, data1_v;
    logic [1:0]      ack0_v, ack1_v, err_v, start_v, owner_v, busy_v;
    logic [1:0][7:0] sa_v, sd_v;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    int         gap_p[2], bt_p[2], dt_p[2];
    int         idle_from[2], rq_cyc[2];
    bit         last_m[2], win_m[2];
    logic [7:0] ea_m[2], ed_m[2], own_seq[2];
    int         n_ack[2][2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sccb_arbiter #(
        .PRIORITY_MODE(0), .GAP_CYCLES(GAP_A),
        .BUSY_TIMEOUT(BT_A), .DONE_TIMEOUT(DT_A)
    ) dut_a (
        .clk(clk), .reset(reset),
        .req0(req0_v[0]), .addr0(addr0_v[0]), .data0(data0_v[0]),
        .ack0(ack0_v[0]),
        .req1(req1_v[0]), .addr1(addr1_v[0]), .data1(data1_v[0]),
        .ack1(ack1_v[0]),
        .err(err_v[0]), .sccb_ready(rdy_v[0]), .sccb_start(start_v[0]),
        .sccb_sub_address(sa_v[0]), .sccb_set_data(sd_v[0]),
        .owner(owner_v[0]), .busy(busy_v[0])
    );

    sccb_arbiter #(
        .PRIORITY_MODE(1), .GAP_CYCLES(GAP_B),
        .BUSY_TIMEOUT(BT_B), .DONE_TIMEOUT(DT_B)
    ) dut_b (
        .clk(clk), .reset(reset),
        .req0(req0_v[1]), .addr0(addr0_v[1]), .data0(data0_v[1]),
        .ack0(ack0_v[1]),
        .req1(req1_v[1]), .addr1(addr1_v[1]), .data1(data1_v[1]),
        .ack1(ack1_v[1]),
        .err(err_v[1]), .sccb_ready(rdy_v[1]), .sccb_start(start_v[1]),
        .sccb_sub_address(sa_v[1]), .sccb_set_data(sd_v[1]),
        .owner(owner_v[1]), .busy(busy_v[1])
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [31:0] outs(input int d);
        return {10'd0, ack0_v[d], ack1_v[d], err_v[d], start_v[d],
                owner_v[d], busy_v[d], sa_v[d], sd_v[d]};
    endfunction

    // Policy model: fixed (dut 1) always prefers req0; round-robin
    // prefers whichever requester was not served last.
    function automatic bit pick(input int d);
        if (req0_v[d] && req1_v[d]) begin
            if (d == 1) return 1'b0;
            return (last_m[d] == 1'b0);
        end
        return req1_v[d];
    endfunction

    task automatic do_reset(input int n);
        reset  = 1'b1;
        req0_v = '0;
        req1_v = '0;
        rdy_v  = 2'b11;
        repeat (n) tick();
        check("rst_out_a", outs(0), 32'd0);
        check("rst_out_b", outs(1), 32'd0);
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            idle_from[d] = cyc;
            rq_cyc[d]    = cyc;
            last_m[d]    = 1'b1;
        end
    endtask

    task automatic raise(input int d, input int r);
        if (r == 0) begin
            req0_v[d]  = 1'b1;
            addr0_v[d] = 8'($urandom);
            data0_v[d] = 8'($urandom);
        end else begin
            req1_v[d]  = 1'b1;
            addr1_v[d] = 8'($urandom);
            data1_v[d] = 8'($urandom);
        end
        rq_cyc[d] = cyc;
    endtask

    task automatic wait_start(input int d, output int s);
        int exp_s;
        exp_s    = ((idle_from[d] > rq_cyc[d]) ? idle_from[d] : rq_cyc[d]) + 1;
        win_m[d] = pick(d);
        ea_m[d]  = win_m[d] ? addr1_v[d] : addr0_v[d];
        ed_m[d]  = win_m[d] ? data1_v[d] : data0_v[d];
        s = -1;
        for (int i = 0; i < 1000 && s < 0; i++) begin
            if (start_v[d]) s = cyc;
            else tick();
        end
        check("start_cyc", s, exp_s);
        check("owner", owner_v[d], win_m[d]);
        check("sub_addr", sa_v[d], ea_m[d]);
        check("set_data", sd_v[d], ed_m[d]);
        check("busy_issue", busy_v[d], 1'b1);
        own_seq[d] = {own_seq[d][6:0], owner_v[d]};
        if (win_m[d]) begin
            addr1_v[d] = 8'($urandom);
            data1_v[d] = 8'($urandom);
        end else begin
            addr0_v[d] = 8'($urandom);
            data0_v[d] = 8'($urandom);
        end
        if (s < 0) s = cyc;
    endtask

    // Engine model: ready falls bd cycles after start (0 = never) and
    // rises dd cycles later (0 = never).
    task automatic finish(input int d, input int s, input int bd,
                          input int dd, input bit keep);
        int ea;
        int a;
        bit ee;
        if (bd == 0) begin
            ea = s + bt_p[d];
            ee = 1'b1;
        end else if (dd == 0) begin
            ea = s + bd + dt_p[d];
            ee = 1'b1;
        end else begin
            ea = s + bd + dd + 1;
            ee = 1'b0;
        end
        a = -1;
        while (a < 0 && cyc <= ea + 4) begin
            if (bd == 0) rdy_v[d] = 1'b1;
            else rdy_v[d] = !(cyc >= s + bd && (dd == 0 || cyc < s + bd + dd));
            if (ack0_v[d] || ack1_v[d]) a = cyc;
            else tick();
        end
        check("ack_cyc", a, ea);
        check("ack_who", {ack1_v[d], ack0_v[d]}, win_m[d] ? 2'b10 : 2'b01);
        check("err", err_v[d], ee);
        check("hold_ad", {sa_v[d], sd_v[d]}, {ea_m[d], ed_m[d]});
        if (ack0_v[d]) n_ack[d][0]++;
        if (ack1_v[d]) n_ack[d][1]++;
        if (a < 0) a = cyc;
        rdy_v[d]     = 1'b1;
        last_m[d]    = win_m[d];
        idle_from[d] = a + gap_p[d] + 1;
        if (win_m[d]) req1_v[d] = 1'b0;
        else req0_v[d] = 1'b0;
        if (keep) raise(d, int'(win_m[d]));
    endtask

    task automatic txn(input int d, input int bd, input int dd, input bit keep);
        int s;
        wait_start(d, s);
        finish(d, s, bd, dd, keep);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int n;
        int bd;
        int dd;
        int pat;
        gap_p[0] = GAP_A; bt_p[0] = BT_A; dt_p[0] = DT_A;
        gap_p[1] = GAP_B; bt_p[1] = BT_B; dt_p[1] = DT_B;
        addr0_v = '0; data0_v = '0; addr1_v = '0; data1_v = '0;
        own_seq[0] = '0; own_seq[1] = '0;
        for (int d = 0; d < 2; d++) begin
            n_ack[d][0] = 0;
            n_ack[d][1] = 0;
        end
        do_reset(2);

        // Engine not ready: no grant, then single req0 0x12/0x80.
        rdy_v[0] = 1'b0;
        raise(0, 0);
        addr0_v[0] = 8'h12;
        data0_v[0] = 8'h80;
        n = 0;
        repeat (6) begin
            tick();
            if (start_v[0] || busy_v[0]) n++;
        end
        check("no_grant_unready", n, 0);
        rdy_v[0]  = 1'b1;
        rq_cyc[0] = cyc;
        txn(0, 2, 100, 1'b0);

        // Round-robin with both requesters held.
        do_reset(2);
        own_seq[0] = '0;
        n_ack[0][0] = 0;
        n_ack[0][1] = 0;
        raise(0, 0);
        raise(0, 1);
        repeat (4) txn(0, $urandom_range(1, 3), $urandom_range(1, 40), 1'b1);
        req0_v[0] = 1'b0;
        req1_v[0] = 1'b0;
        check("rr_seq", own_seq[0][3:0], 4'b0101);
        check("rr_acks0", n_ack[0][0], 2);
        check("rr_acks1", n_ack[0][1], 2);

        // Fixed priority: req0 wins three times, then req1.
        own_seq[1] = '0;
        raise(1, 0);
        raise(1, 1);
        txn(1, 1, 3, 1'b1);
        txn(1, 2, 5, 1'b1);
        txn(1, 3, 2, 1'b0);
        txn(1, 1, 1, 1'b0);
        check("fix_seq", own_seq[1][3:0], 4'b0001);

        // Busy timeout, then back through GAP to IDLE.
        raise(0, 1);
        txn(0, 0, 0, 1'b0);
        while (cyc < idle_from[0] - 1) tick();
        check("gap_busy", busy_v[0], 1'b1);
        tick();
        check("idle_busy", busy_v[0], 1'b0);

        // Done timeouts on both instances.
        raise(0, 0);
        txn(0, 3, 0, 1'b0);
        raise(1, 1);
        txn(1, 0, 0, 1'b0);
        raise(1, 0);
        txn(1, 2, 0, 1'b0);

        // Reset while waiting for the engine to finish.
        raise(0, 1);
        wait_start(0, s);
        while (cyc < s + 5) begin
            rdy_v[0] = (cyc < s + 2);
            tick();
        end
        do_reset(1);
        n = 0;
        repeat (8) begin
            tick();
            if (ack0_v[0] || ack1_v[0] || err_v[0] || start_v[0]) n++;
        end
        check("post_rst_quiet", n, 0);
        raise(0, 0);
        txn(0, 1, 5, 1'b0);

        // Randomized traffic on the round-robin instance.
        for (int i = 0; i < 12; i++) begin
            if (!(req0_v[0] || req1_v[0])) begin
                repeat ($urandom_range(0, GAP_A + 6)) tick();
                pat = $urandom_range(1, 3);
                if (pat[0]) raise(0, 0);
                if (pat[1]) raise(0, 1);
            end else if ($urandom_range(0, 1) == 1) begin
                if (req0_v[0]) raise(0, 1);
                else raise(0, 0);
            end
            bd = $urandom_range(1, 3);
            dd = $urandom_range(1, 60);
            if ($urandom_range(0, 7) == 0) bd = 0;
            txn(0, bd, dd, 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            if (req0_v[0] || req1_v[0]) txn(0, 1, 4, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sccb_arbiter.md
Name: sccb_arbiter

Overview:
- Shares the single `sccb_protocol` write engine between two requesters.
  - Requester 0: the power-up register-table sequencer.
  - Requester 1: the runtime register writer (exposure/gain/mirror updates).
- Arbitrates, latches address/data, pulses the engine's start, and tracks the engine's ready through busy and done.
- Enforces a minimum bus-idle gap between transactions and returns a per-requester completion/error handshake.
- Sits between the camera control sequencers and `sccb_protocol`, inside the camera interface top.

Parameters:
- PRIORITY_MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed (req0 wins).
- GAP_CYCLES, 250, minimum idle clk cycles between engine ready rising and the next start pulse (range 1..65535).
- BUSY_TIMEOUT, 16, max cycles after the start pulse for ready to fall (range 2..65535).
- DONE_TIMEOUT, 20000, max cycles with ready low before the transaction is abandoned (range 2..65535).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; one clock, no other clock domains
- req0  in  1  requester 0 request level; held until ack0
- addr0  in  8  requester 0 sub-address
- data0  in  8  requester 0 write data
- ack0  out  1  one-cycle completion pulse to requester 0
- req1, addr1, data1, ack1: as above, for requester 1
- err  out  1  one-cycle pulse, coincident with the ack of a timed-out transaction
- sccb_ready  in  1  ready from `sccb_protocol` (high = idle)
- sccb_start  out  1  one-cycle start pulse to `sccb_protocol`
- sccb_sub_address  out  8  sub-address to the engine
- sccb_set_data  out  8  data to the engine
- owner  out  1  requester currently or last served
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: all outputs 0, state = IDLE, round-robin pointer favours req0, gap counter loaded so that the first grant needs no gap.
  - Reset mid-transaction aborts immediately; no ack, no err.
  - The engine shares the same reset.
- State IDLE: a grant is made only when sccb_ready=1.
  - Round-robin mode:
    - Both requesting: grant the requester not served last.
    - One requesting: grant it.
  - Fixed mode: req0 always wins.
  - On grant, in that cycle: latch addrN/dataN into sccb_sub_address/sccb_set_data, set owner, go to ISSUE.
  - No request: stay in IDLE.
- State ISSUE:
  - sccb_start=1 for exactly this cycle; clear the counter; go to WAIT_BUSY.
  - Address/data stay stable from ISSUE until the next grant.
- State WAIT_BUSY:
  - sccb_ready=0: go to WAIT_DONE, clear the counter.
  - Otherwise increment the counter. When it reaches BUSY_TIMEOUT-1, go to FINISH with the error flag set.
- State WAIT_DONE:
  - sccb_ready=1: go to FINISH, error flag clear.
  - Otherwise increment. At DONE_TIMEOUT-1, go to FINISH with the error flag set.
- State FINISH, one cycle:
  - ackN=1 for the owner, err = error flag.
  - Update the round-robin pointer to the owner.
  - Load the gap counter, go to GAP.
- State GAP:
  - Count GAP_CYCLES cycles, then go to IDLE.
  - Requests are ignored during GAP.
- Latency: req asserted in IDLE at cycle T (with ready=1 and no gap pending) gives sccb_start at T+1.
- Requester rule: deassert req on the clock edge at which ack is sampled high. A req still high after GAP is treated as a new request.
- Changes to addrN/dataN after the grant cycle are ignored.
- Simultaneous req0/req1 in the same IDLE cycle are resolved by the policy. The loser keeps req high and is served after the winner's GAP.
- If sccb_ready=0 in IDLE (engine not yet ready after reset), no grant is made.
- Counters are 16 bits and do not wrap within a transaction.

Test Plan:
- Single req0 (addr0=0x12, data0=0x80); engine model drops ready 2 cycles after start and raises it 100 cycles later -> sccb_start pulses the cycle after req; address/data 0x12/0x80; ack0 one cycle after ready rises; err=0; next start no earlier than 250 cycles later.
- req0 and req1 held continuously in round-robin mode for 4 transactions -> owner sequence 0,1,0,1; each requester gets exactly 2 acks.
- Same stimulus with PRIORITY_MODE=1 and req0 held for 3 transactions -> three grants to req0, req1 served only after req0 drops.
- Engine never drops ready after start -> err and ack pulse together exactly BUSY_TIMEOUT cycles after the start cycle; arbiter returns through GAP to IDLE.
- Engine holds ready low indefinitely -> err/ack DONE_TIMEOUT cycles after ready falls.
- reset asserted during WAIT_DONE -> next cycle all outputs 0, state IDLE, no ack/err; a new req after reset is granted normally.
